// File: rtl/cricket_match_ctrl_if.sv
// cricket_match_ctrl_if
//   Groups the ball-event inputs and the scoreboard outputs of cricket_match_ctrl.
//   Clock and reset stay plain ports on the controller.
//
//   Signals:
//     ball_valid      one-cycle pulse, a ball has been bowled
//     ball_result     0..6 runs, 7 = wicket (0 runs)
//     ball_extra      wide/no-ball flag (only with EXTRAS_EN defined)
//     next_inning     one-cycle pulse, leave the innings break
//     binary_runs     runs of the current / last-completed innings
//     binary_wickets  wickets of the current / last-completed innings
//     balls_bowled    legal balls bowled this innings
//     inning_over     high while in the innings break
//     game_over       high once the match is decided
//     winner          0 = team 1, 1 = team 2 (valid with game_over)
//
//   Modports: master = stimulus side (front end), slave = controller.
//   Optional feature macro: EXTRAS_EN.
interface cricket_match_ctrl_if;
  logic       ball_valid;
  logic [2:0] ball_result;
`ifdef EXTRAS_EN
  logic       ball_extra;
`endif
  logic       next_inning;
  logic [7:0] binary_runs;
  logic [3:0] binary_wickets;
  logic [5:0] balls_bowled;
  logic       inning_over;
  logic       game_over;
  logic       winner;

  modport master (
    output ball_valid,
    output ball_result,
`ifdef EXTRAS_EN
    output ball_extra,
`endif
    output next_inning,
    input  binary_runs,
    input  binary_wickets,
    input  balls_bowled,
    input  inning_over,
    input  game_over,
    input  winner
  );

  modport slave (
    input  ball_valid,
    input  ball_result,
`ifdef EXTRAS_EN
    input  ball_extra,
`endif
    input  next_inning,
    output binary_runs,
    output binary_wickets,
    output balls_bowled,
    output inning_over,
    output game_over,
    output winner
  );
endinterface

// File: rtl/cricket_match_ctrl.sv
// cricket_match_ctrl
//   Sequences a two-innings limited-overs match: accumulates runs, wickets and
//   balls of the batting team, schedules the innings break, holds the
//   first-innings target and latches the winner. All outputs are registered.
//
//   Ports:
//     clk    system clock
//     reset  asynchronous, active-high reset
//     bus    cricket_match_ctrl_if.slave (ball events in, scoreboard values out)
//
//   Parameters:
//     BALLS_PER_INNINGS  legal balls per innings, 1..63
//     MAX_WICKETS        wickets that end an innings, 1..15
//
//   Optional feature macro: EXTRAS_EN adds bus.ball_extra (wides/no-balls).
module cricket_match_ctrl #(
  parameter int unsigned BALLS_PER_INNINGS = 12,
  parameter int unsigned MAX_WICKETS       = 10
) (
  input logic                 clk,
  input logic                 reset,
  cricket_match_ctrl_if.slave bus
);

  localparam logic [5:0] BallsLimit = 6'(BALLS_PER_INNINGS);
  localparam logic [3:0] WktLimit   = 4'(MAX_WICKETS);

  typedef enum logic [1:0] {StInn1, StBreak, StInn2, StDone} state_e;

  state_e     state_q;
  logic [7:0] runs_q;
  logic [3:0] wkts_q;
  logic [5:0] balls_q;
  logic [7:0] target_q;
  logic       inning_over_q;
  logic       game_over_q;
  logic       winner_q;

  // Next counter values if the current ball is processed.
  logic       is_wicket;
  logic       is_extra;
  logic [2:0] base_runs;
  logic [3:0] add_runs;
  logic [8:0] runs_sum;
  logic [7:0] runs_nxt;
  logic [3:0] wkts_nxt;
  logic [5:0] balls_nxt;
  logic       innings_end;
  logic       chase_won;

  always_comb begin
    is_wicket = (bus.ball_result == 3'd7);
`ifdef EXTRAS_EN
    is_extra  = bus.ball_extra;
`else
    is_extra  = 1'b0;
`endif
    // Code 7 never scores: on a legal ball it is a wicket, on an extra it counts as 0.
    base_runs = is_wicket ? 3'd0 : bus.ball_result;
    add_runs  = is_extra ? ({1'b0, base_runs} + 4'd1) : {1'b0, base_runs};
    runs_sum  = {1'b0, runs_q} + {5'd0, add_runs};
    runs_nxt  = runs_sum[8] ? 8'hFF : runs_sum[7:0];

    wkts_nxt = wkts_q;
    if (!is_extra && is_wicket && (wkts_q < WktLimit)) begin
      wkts_nxt = wkts_q + 4'd1;
    end

    balls_nxt = balls_q;
    if (!is_extra && (balls_q < BallsLimit)) begin
      balls_nxt = balls_q + 6'd1;
    end

    innings_end = (wkts_nxt == WktLimit) || (balls_nxt == BallsLimit);
    chase_won   = (runs_nxt > target_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StInn1;
      runs_q        <= 8'd0;
      wkts_q        <= 4'd0;
      balls_q       <= 6'd0;
      target_q      <= 8'd0;
      inning_over_q <= 1'b0;
      game_over_q   <= 1'b0;
      winner_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StInn1: begin
          if (bus.ball_valid) begin
            runs_q  <= runs_nxt;
            wkts_q  <= wkts_nxt;
            balls_q <= balls_nxt;
            if (innings_end) begin
              state_q       <= StBreak;
              target_q      <= runs_nxt;
              inning_over_q <= 1'b1;
            end
          end
        end
        StBreak: begin
          // Counters hold team 1's totals; a simultaneous ball is dropped.
          if (bus.next_inning) begin
            state_q       <= StInn2;
            runs_q        <= 8'd0;
            wkts_q        <= 4'd0;
            balls_q       <= 6'd0;
            inning_over_q <= 1'b0;
          end
        end
        StInn2: begin
          if (bus.ball_valid) begin
            runs_q  <= runs_nxt;
            wkts_q  <= wkts_nxt;
            balls_q <= balls_nxt;
            // Passing the target wins even on the last ball or last wicket.
            if (chase_won) begin
              state_q     <= StDone;
              game_over_q <= 1'b1;
              winner_q    <= 1'b1;
            end else if (innings_end) begin
              state_q     <= StDone;
              game_over_q <= 1'b1;
              winner_q    <= 1'b0;
            end
          end
        end
        StDone: begin
          // Frozen until reset.
        end
        default: begin
          state_q <= StInn1;
        end
      endcase
    end
  end

  assign bus.binary_runs    = runs_q;
  assign bus.binary_wickets = wkts_q;
  assign bus.balls_bowled   = balls_q;
  assign bus.inning_over    = inning_over_q;
  assign bus.game_over      = game_over_q;
  assign bus.winner         = winner_q;

endmodule

// File: tb/tb_cricket_match_ctrl.sv
// tb_cricket_match_ctrl
//   Directed stimulus with hand-computed expectations pushed into a queue; a
//   monitor pops one entry after each clock edge that follows a push and
//   compares against the selected DUT. dut0 uses the default parameters,
//   dut1 uses BALLS_PER_INNINGS = 63 for the saturation case.
module tb_cricket_match_ctrl;

  logic clk;
  logic reset;

  cricket_match_ctrl_if bus0 ();
  cricket_match_ctrl_if bus1 ();

  cricket_match_ctrl #(
    .BALLS_PER_INNINGS(12),
    .MAX_WICKETS      (10)
  ) dut0 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus0.slave)
  );

  cricket_match_ctrl #(
    .BALLS_PER_INNINGS(63),
    .MAX_WICKETS      (10)
  ) dut1 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         sel;
    logic [7:0] runs;
    logic [3:0] wkts;
    logic [5:0] balls;
    logic       io;
    logic       go;
    logic       win;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [20:0] pack(input logic [7:0] r, input logic [3:0] w,
                                       input logic [5:0] b, input logic io,
                                       input logic go, input logic win);
    return {r, w, b, io, go, win};
  endfunction

  task automatic compare(input string name, input logic [20:0] act, input logic [20:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got runs=%0d wk=%0d balls=%0d io=%b go=%b win=%b, want runs=%0d wk=%0d balls=%0d io=%b go=%b win=%b",
               name, act[20:13], act[12:9], act[8:3], act[2], act[1], act[0],
               exp[20:13], exp[12:9], exp[8:3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [20:0] observe(input bit sel);
    if (sel) begin
      return pack(bus1.binary_runs, bus1.binary_wickets, bus1.balls_bowled,
                  bus1.inning_over, bus1.game_over, bus1.winner);
    end
    return pack(bus0.binary_runs, bus0.binary_wickets, bus0.balls_bowled,
                bus0.inning_over, bus0.game_over, bus0.winner);
  endfunction

  // Monitor: one expectation per clock edge that follows a push.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare(e.name, observe(e.sel), pack(e.runs, e.wkts, e.balls, e.io, e.go, e.win));
      end
    end
  end

  task automatic clear_inputs();
    bus0.ball_valid  = 1'b0;
    bus0.ball_result = 3'd0;
    bus0.next_inning = 1'b0;
    bus1.ball_valid  = 1'b0;
    bus1.ball_result = 3'd0;
    bus1.next_inning = 1'b0;
`ifdef EXTRAS_EN
    bus0.ball_extra  = 1'b0;
    bus1.ball_extra  = 1'b0;
`endif
  endtask

  // Drive one cycle of stimulus and queue the state expected after the next edge.
  task automatic step(input bit sel, input bit v, input logic [2:0] r, input bit ext,
                      input bit nx, input logic [7:0] er, input logic [3:0] ew,
                      input logic [5:0] eb, input logic eio, input logic ego,
                      input logic ewin, input string name);
    exp_t e;
    @(negedge clk);
    clear_inputs();
    if (sel) begin
      bus1.ball_valid  = v;
      bus1.ball_result = r;
      bus1.next_inning = nx;
`ifdef EXTRAS_EN
      bus1.ball_extra  = ext;
`endif
    end else begin
      bus0.ball_valid  = v;
      bus0.ball_result = r;
      bus0.next_inning = nx;
`ifdef EXTRAS_EN
      bus0.ball_extra  = ext;
`endif
    end
    if (ext && sel) e.sel = 1'b1;  // keeps ext referenced in every build
    e.sel   = sel;
    e.runs  = er;
    e.wkts  = ew;
    e.balls = eb;
    e.io    = eio;
    e.go    = ego;
    e.win   = ewin;
    e.name  = name;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // First innings of twelve singles on dut0: target becomes 12.
  task automatic twelve_ones();
    for (int i = 1; i <= 12; i++) begin
      step(0, 1, 3'd1, 0, 0, 8'(i), 4'd0, 6'(i), (i == 12), 1'b0, 1'b0, "inn1_single");
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state on both instances.
    step(0, 0, 3'd0, 0, 0, 8'd0, 4'd0, 6'd0, 0, 0, 0, "reset_state0");
    step(1, 0, 3'd0, 0, 0, 8'd0, 4'd0, 6'd0, 0, 0, 0, "reset_state1");
    step(0, 0, 3'd0, 0, 1, 8'd0, 4'd0, 6'd0, 0, 0, 0, "next_ignored_inn1");

    // Balls exhausted -> BREAK; balls ignored in BREAK; ball+next drops the ball.
    twelve_ones();
    step(0, 1, 3'd6, 0, 0, 8'd12, 4'd0, 6'd12, 1, 0, 0, "break_ignores_ball");
    step(0, 1, 3'd4, 0, 0, 8'd12, 4'd0, 6'd12, 1, 0, 0, "break_ignores_ball2");
    step(0, 1, 3'd5, 0, 1, 8'd0, 4'd0, 6'd0, 0, 0, 0, "next_drops_ball");

    // All out after ten wickets; INN2 against target 0 is won by the first run.
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      step(0, 1, 3'd7, 0, 0, 8'd0, 4'(i), 6'(i), (i == 10), 1'b0, 1'b0, "inn1_wicket");
    end
    step(0, 0, 3'd0, 0, 1, 8'd0, 4'd0, 6'd0, 0, 0, 0, "next_clears");
    step(0, 1, 3'd1, 0, 0, 8'd1, 4'd0, 6'd1, 0, 1, 1, "chase_target0");
    step(0, 1, 3'd6, 0, 1, 8'd1, 4'd0, 6'd1, 0, 1, 1, "done_frozen");

    // Target 12, chase with 6, 6, 1.
    do_reset();
    twelve_ones();
    step(0, 0, 3'd0, 0, 1, 8'd0, 4'd0, 6'd0, 0, 0, 0, "next_inn2");
    step(0, 1, 3'd6, 0, 0, 8'd6, 4'd0, 6'd1, 0, 0, 0, "chase_six");
    step(0, 1, 3'd6, 0, 0, 8'd12, 4'd0, 6'd2, 0, 0, 0, "chase_level");
    step(0, 1, 3'd1, 0, 0, 8'd13, 4'd0, 6'd3, 0, 1, 1, "chase_won");
    step(0, 1, 3'd4, 0, 0, 8'd13, 4'd0, 6'd3, 0, 1, 1, "won_frozen");
    step(0, 1, 3'd7, 0, 1, 8'd13, 4'd0, 6'd3, 0, 1, 1, "won_frozen2");

    // Target 12, INN2 reaches exactly 12 on the final ball: tie to team 1.
    do_reset();
    twelve_ones();
    step(0, 0, 3'd0, 0, 1, 8'd0, 4'd0, 6'd0, 0, 0, 0, "next_inn2_tie");
    step(0, 1, 3'd7, 0, 0, 8'd0, 4'd1, 6'd1, 0, 0, 0, "tie_wicket");
    for (int i = 1; i <= 10; i++) begin
      step(0, 1, 3'd1, 0, 0, 8'(i), 4'd1, 6'(i + 1), 1'b0, 1'b0, 1'b0, "tie_single");
    end
    step(0, 1, 3'd2, 0, 0, 8'd12, 4'd1, 6'd12, 0, 1, 0, "tie_last_ball");
    step(0, 1, 3'd6, 0, 0, 8'd12, 4'd1, 6'd12, 0, 1, 0, "tie_frozen");

    // Reset mid-INN2 with runs 7: outputs clear before any edge.
    do_reset();
    twelve_ones();
    step(0, 0, 3'd0, 0, 1, 8'd0, 4'd0, 6'd0, 0, 0, 0, "next_inn2_rst");
    step(0, 1, 3'd6, 0, 0, 8'd6, 4'd0, 6'd1, 0, 0, 0, "rst_six");
    step(0, 1, 3'd1, 0, 0, 8'd7, 4'd0, 6'd2, 0, 0, 0, "rst_seven");
    @(negedge clk);
    clear_inputs();
    #1 reset = 1'b1;
    #1 compare("async_reset", observe(0), pack(8'd0, 4'd0, 6'd0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    reset = 1'b0;
    step(0, 0, 3'd0, 0, 0, 8'd0, 4'd0, 6'd0, 0, 0, 0, "after_reset");
    // Target is 0 again, so a run must not end the game: proves INN1.
    step(0, 1, 3'd3, 0, 0, 8'd3, 4'd0, 6'd1, 0, 0, 0, "restart_inn1");

    // Saturation on dut1 (63 balls per innings).
    do_reset();
    for (int i = 1; i <= 50; i++) begin
      step(1, 1, 3'd6, 0, 0, ((6 * i) > 255) ? 8'd255 : 8'(6 * i), 4'd0, 6'(i),
           1'b0, 1'b0, 1'b0, "saturate");
    end

`ifdef EXTRAS_EN
    do_reset();
    step(0, 1, 3'd4, 1, 0, 8'd5, 4'd0, 6'd0, 0, 0, 0, "extra_four");
    step(0, 1, 3'd7, 1, 0, 8'd6, 4'd0, 6'd0, 0, 0, 0, "extra_code7");
    step(0, 1, 3'd7, 0, 0, 8'd6, 4'd1, 6'd1, 0, 0, 0, "legal_wicket");
`endif

    @(negedge clk);
    clear_inputs();
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cricket_match_ctrl.md
# cricket_match_ctrl

Sequences a two-innings limited-overs cricket match and drives the scoreboard's binary-to-BCD display stage. Ball events come in as one-cycle pulses from the debounced button/switch front end. The block accumulates runs, wickets and balls for the batting team. It schedules the innings break, holds the first-innings target, and decides and latches the winner. Its outputs feed the display converter's runs, wickets, innings-over, game-over and winner inputs directly.

## Interface
Parameters:
- BALLS_PER_INNINGS, 12: legal balls per innings, 1..63.
- MAX_WICKETS, 10: wickets that end an innings, 1..15.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ball_valid  in  1  one-cycle pulse: a ball has been bowled.
- ball_result  in  3  sampled with ball_valid. 0..6 = runs scored; 7 = wicket, 0 runs.
- next_inning  in  1  one-cycle pulse: leave the innings break.
- binary_runs  out  8  runs of the current or last-completed innings.
- binary_wickets  out  4  wickets of the current or last-completed innings.
- balls_bowled  out  6  legal balls bowled this innings.
- inning_over  out  1  high only in state BREAK.
- game_over  out  1  high only in state DONE.
- winner  out  1  0 = team 1, 1 = team 2. Valid while game_over is high.

## Operation
- States are INN1, BREAK, INN2 and DONE. Reset enters INN1.
- Processing a ball in INN1 or INN2:
  - runs increase by ball_result; for code 7, wickets increase by 1;
  - balls_bowled increases by 1.
- Runs saturate at 255. Wickets never exceed MAX_WICKETS.
- INN1 -> BREAK when the processed ball leaves wickets == MAX_WICKETS or balls_bowled == BALLS_PER_INNINGS. The final runs value is copied into the target register.
- BREAK:
  - runs, wickets and balls hold team 1's final values;
  - ball_valid is ignored;
  - next_inning moves to INN2 and clears runs, wickets and balls to 0.
- INN2 -> DONE with winner = 1 as soon as runs > target. This check takes priority over the all-out and balls-exhausted checks on the same ball.
- INN2 -> DONE with winner = 0 on all out or balls exhausted while runs <= target. A tie is awarded to team 1.
- DONE:
  - all outputs are frozen;
  - ball_valid and next_inning are ignored;
  - only reset leaves DONE.
- next_inning outside BREAK is ignored.
- Reset values: state INN1, runs 0, wickets 0, balls 0, target 0, inning_over 0, game_over 0, winner 0.

## Timing
- All outputs are registered. A ball on edge N is visible on every output after edge N. Latency is 1 cycle, and a ball pulse can be accepted on every cycle.
- A ball that ends an innings updates the counters and the state on the same edge. inning_over or game_over is high in the next cycle, together with the final counter values.
- When ball_valid and next_inning are both high in BREAK, the state moves to INN2 and the ball is dropped.
- Asserting reset mid-innings or mid-break forces the reset values immediately, without waiting for a clock edge. Operation restarts in INN1 on the first edge after reset deasserts.

## Configuration
- EXTRAS_EN
  - Defined:
    - adds input ball_extra (1 bit), sampled with ball_valid;
    - an extra (wide or no-ball) adds 1 + ball_result runs, with code 7 treated as 0;
    - an extra adds no wicket and does not increment balls_bowled;
    - the saturation and target checks apply unchanged.
  - Undefined: the port is absent and every ball is legal.

## Test plan
- Reset, then 12 balls of result 1: after the 12th ball, runs = 12, balls = 12 and inning_over = 1. Further ball_valid pulses leave runs at 12.
- Ten result-7 balls in INN1: BREAK after the 10th ball with wickets = 10 and balls = 10. next_inning then shows runs = 0, wickets = 0, balls = 0 and inning_over = 0.
- Target 12, then INN2 balls of 6, 6, 1: game_over = 1 and winner = 1 after the third ball, with runs = 13. Later balls leave outputs frozen.
- Target 12, then INN2 runs reach exactly 12 on the final ball: game_over = 1 and winner = 0 (tie goes to team 1).
- In INN1, 50 balls of result 6 with BALLS_PER_INNINGS = 63: runs saturate at 255.
- Assert reset mid-INN2 with runs = 7: all outputs read 0 before the next clock edge, and the state is INN1 after release.
- With EXTRAS_EN defined, ball_extra with result 4: runs += 5 and balls_bowled is unchanged.
